apb_timer_8bit: RTL and testbench
=================================

Name: apb_timer_8bit

Overview:
- 8-bit up/down timer with an APB slave register interface.
- The counter advances on a prescaled tick derived from pclk: pclk/2, /4, /8 or /16.
- Wrap-around events set sticky overflow and underflow flags, which are readable and clearable over APB and mirrored as interrupt outputs.
- The block sits on the peripheral APB bus behind a CPU bus-functional master.

Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 8, APB data and register width.

Ports:
- pclk  in  1  system/APB clock.
- preset  in  1  asynchronous reset, active-high.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  8  register address.
- pwdata  in  8  write data.
- prdata  out  8  read data.
- pready  out  1  transfer ready.
- pslverr  out  1  transfer error.
- tmr_ovf  out  1  equals TSR[0].
- tmr_udf  out  1  equals TSR[1].

Behaviour:
- One clock (pclk). Reset is asynchronous and active-high (preset). All registers, the counter and the prescaler clear to 0 on reset; prdata=0, pslverr=0, tmr_ovf=0, tmr_udf=0.
- APB transfers have zero wait states: pready=1 whenever psel&penable.
- Writes commit on the pclk edge where psel&penable&pwrite.
- prdata is combinational from paddr while psel&!pwrite.
- pslverr=1 in the access phase for paddr>0x03, and also for writes to 0x03. Such writes have no effect; such reads return 0.
- Register map:
  - 0x00 TDR, RW: reload value.
  - 0x01 TCR, RW:
    - bit7 load.
    - bit5 dir (1 = down, 0 = up).
    - bit4 en.
    - bits1:0 cks (00 = /2, 01 = /4, 10 = /8, 11 = /16).
    - bits 6, 3, 2 are reserved: write-ignored, read 0.
  - 0x02 TSR: bit0 OVF, bit1 UDF, bits7:2 read 0. Writing 0 to a flag bit clears it; writing 1 leaves it unchanged.
  - 0x03 TCNT, RO: current count.
- Load: while TCR.load=1, TCNT<=TDR every cycle and the prescaler is held at 0. Load has priority over counting.
- Prescaler:
  - Free-running divider, cleared while en=0 or load=1 or when cks is written.
  - Divide ratio N = 2^(cks+1). Produces a 1-cycle tick every N pclk cycles while en=1 and load=0.
  - The first tick occurs N cycles after the counter is enabled.
- Counting on tick:
  - dir=0: TCNT+1, wraps 0xFF->0x00 and sets OVF.
  - dir=1: TCNT-1, wraps 0x00->0xFF and sets UDF.
- Flags are sticky until cleared by software.
- If a hardware set and a software clear of the same flag occur in the same cycle, the set wins.
- Changing dir or en mid-count takes effect from the next cycle; TCNT is preserved.
- Reset mid-operation returns everything to reset values immediately.

Decomposition:
- Package apb_timer_pkg holds:
  - address constants ADDR_TDR, ADDR_TCR, ADDR_TSR, ADDR_TCNT;
  - TCR bit positions (LOAD, DIR, EN, CKS msb/lsb);
  - TSR bit positions (OVF, UDF);
  - a cks enum.
- One sub-module, timer_prescaler: inputs cks, en, clr; output tick.
- Register file and counter stay in the top module.

Test Plan:
- Reset, then read 0x00..0x03 -> all read 0x00, pslverr=0, tmr_ovf=tmr_udf=0.
- Write TDR=0xFF, TCR=0x81, then TCR=0x31 (down, /4): TSR=0x00 at 1000 pclk, TSR=0x02 at 1024+ pclk with tmr_udf=1. Then write TSR=0x00 -> TSR reads 0x00.
- TDR=0x00, TCR=0x80 then 0x03 (/16) then 0x13 (up): OVF set after 256*16 pclk, TSR=0x01, TCNT=0x00; no flag at 255*16 pclk.
- Load priority: TCR=0x90 (load+en) with TDR=0x55 -> TCNT stays 0x55 for 100 cycles, no flags.
- Prescaler /2, down from TDR=0x02 -> TCNT reads 0x01 after 2 pclk, 0x00 after 4, 0xFF with UDF after 6.
- Write TSR=0xFF while UDF=1 -> flag unchanged. Write 0x01 on the same cycle as an underflow -> UDF remains 1. Access to paddr 0x04 -> pslverr=1, prdata=0.

Source files
------------

// File: rtl/apb_timer_8bit_pkg.sv
// ============================================================================
//  Module      : apb_timer_pkg
//  Description : Shared constants and types for the 8-bit APB timer:
//                register addresses, TCR/TSR bit positions, the clock-select
//                enum and a helper that maps a clock select to the last
//                prescaler count before a tick.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_timer_pkg;

    // Register addresses
    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;

    // TCR bit positions
    localparam int TCR_LOAD_BIT = 7;
    localparam int TCR_DIR_BIT  = 5;
    localparam int TCR_EN_BIT   = 4;
    localparam int TCR_CKS_MSB  = 1;
    localparam int TCR_CKS_LSB  = 0;

    // TSR bit positions
    localparam int TSR_OVF_BIT = 0;
    localparam int TSR_UDF_BIT = 1;

    // Prescaler clock select: divide by 2^(cks+1)
    typedef enum logic [1:0] {
        CKS_DIV2  = 2'b00,
        CKS_DIV4  = 2'b01,
        CKS_DIV8  = 2'b10,
        CKS_DIV16 = 2'b11
    } cks_e;

    // Terminal prescaler count (N-1) for a given clock select
    function automatic logic [3:0] cks_last(input cks_e cks);
        logic [3:0] last;
        case (cks)
            CKS_DIV2:  last = 4'd1;
            CKS_DIV4:  last = 4'd3;
            CKS_DIV8:  last = 4'd7;
            CKS_DIV16: last = 4'd15;
            default:   last = 4'd1;
        endcase
        return last;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_timer_8bit_if.sv
// ============================================================================
//  Module      : apb_timer_8bit_if
//  Description : APB bus bundle between the CPU bus-functional master and
//                the timer slave.
//  Ports       : psel, penable, pwrite, paddr, pwdata  (master -> slave)
//                prdata, pready, pslverr               (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_timer_8bit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

`default_nettype wire

// File: rtl/apb_timer_8bit_prescaler.sv
// ============================================================================
//  Module      : timer_prescaler
//  Description : Free-running clock divider producing a one-cycle tick every
//                2^(cks+1) pclk cycles while enabled. Held at zero while
//                disabled or while clr is asserted.
//  Ports       : pclk, preset      clock, async active-high reset
//                cks               clock select
//                en                count enable
//                clr               synchronous clear (load active / TCR write)
//                tick              one-cycle count strobe
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_prescaler
    import apb_timer_pkg::*;
(
    input  wire logic pclk,
    input  wire logic preset,
    input  wire cks_e cks,
    input  wire logic en,
    input  wire logic clr,
    output logic      tick
);

    logic [3:0] div_q;
    logic [3:0] div_d;

    // Tick in the cycle the divider sits at N-1, so the first tick lands
    // N cycles after the divider leaves its cleared state.
    assign tick = en && !clr && (div_q == cks_last(cks));

    always_comb begin
        div_d = div_q + 4'd1;
        if (!en || clr || tick) begin
            div_d = 4'd0;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            div_q <= 4'd0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_timer_8bit.sv
// ============================================================================
//  Module      : apb_timer_8bit
//  Description : 8-bit up/down timer with an APB slave register interface.
//                Registers: TDR (reload), TCR (control), TSR (sticky flags),
//                TCNT (read-only count). Zero wait-state APB.
//  Ports       : pclk, preset      clock, async active-high reset
//                apb               APB slave modport
//                tmr_ovf           overflow flag (TSR.OVF)
//                tmr_udf           underflow flag (TSR.UDF)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_timer_8bit
    import apb_timer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
)(
    input  wire logic       pclk,
    input  wire logic       preset,
    apb_timer_8bit_if.slave apb,
    output logic            tmr_ovf,
    output logic            tmr_udf
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tdr_q,  tdr_d;
    logic [DATA_W-1:0] tcnt_q, tcnt_d;
    logic              load_q, load_d;
    logic              dir_q,  dir_d;
    logic              en_q,   en_d;
    cks_e              cks_q,  cks_d;
    logic              ovf_q,  ovf_d;
    logic              udf_q,  udf_d;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_addr;
    logic              w_access;
    logic              w_err;
    logic              w_wr;
    logic              w_wr_tdr;
    logic              w_wr_tcr;
    logic              w_wr_tsr;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_tcr;
    logic [DATA_W-1:0] w_tsr;
    logic              w_tick;
    logic              w_ovf_set;
    logic              w_udf_set;

    assign w_addr   = apb.paddr;
    assign w_access = apb.psel && apb.penable;
    // Unmapped addresses and writes to the read-only counter are errors
    assign w_err    = (w_addr > ADDR_TCNT) || (apb.pwrite && (w_addr == ADDR_TCNT));
    assign w_wr     = w_access && apb.pwrite && !w_err;
    assign w_wr_tdr = w_wr && (w_addr == ADDR_TDR);
    assign w_wr_tcr = w_wr && (w_addr == ADDR_TCR);
    assign w_wr_tsr = w_wr && (w_addr == ADDR_TSR);

    assign apb.pready  = w_access;
    assign apb.pslverr = w_access && w_err;
    assign apb.prdata  = w_rdata;

    always_comb begin
        w_tcr                          = '0;
        w_tcr[TCR_LOAD_BIT]            = load_q;
        w_tcr[TCR_DIR_BIT]             = dir_q;
        w_tcr[TCR_EN_BIT]              = en_q;
        w_tcr[TCR_CKS_MSB:TCR_CKS_LSB] = cks_q;

        w_tsr              = '0;
        w_tsr[TSR_OVF_BIT] = ovf_q;
        w_tsr[TSR_UDF_BIT] = udf_q;

        w_rdata = '0;
        if (apb.psel && !apb.pwrite) begin
            case (w_addr)
                ADDR_TDR:  w_rdata = tdr_q;
                ADDR_TCR:  w_rdata = w_tcr;
                ADDR_TSR:  w_rdata = w_tsr;
                ADDR_TCNT: w_rdata = tcnt_q;
                default:   w_rdata = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prescaler: restarted by load and by any TCR write (cks may change)
    // ------------------------------------------------------------------
    timer_prescaler u_prescaler (
        .pclk   (pclk),
        .preset (preset),
        .cks    (cks_q),
        .en     (en_q),
        .clr    (load_q || w_wr_tcr),
        .tick   (w_tick)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        tdr_d  = tdr_q;
        load_d = load_q;
        dir_d  = dir_q;
        en_d   = en_q;
        cks_d  = cks_q;

        if (w_wr_tdr) begin
            tdr_d = apb.pwdata;
        end
        if (w_wr_tcr) begin
            load_d = apb.pwdata[TCR_LOAD_BIT];
            dir_d  = apb.pwdata[TCR_DIR_BIT];
            en_d   = apb.pwdata[TCR_EN_BIT];
            cks_d  = cks_e'(apb.pwdata[TCR_CKS_MSB:TCR_CKS_LSB]);
        end

        // Load has priority over counting
        tcnt_d    = tcnt_q;
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        if (load_q) begin
            tcnt_d = tdr_q;
        end else if (w_tick) begin
            if (dir_q) begin
                tcnt_d    = tcnt_q - 1'b1;
                w_udf_set = (tcnt_q == '0);
            end else begin
                tcnt_d    = tcnt_q + 1'b1;
                w_ovf_set = (tcnt_q == '1);
            end
        end

        // Write-0-to-clear; a hardware set in the same cycle wins
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (w_wr_tsr && !apb.pwdata[TSR_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
        if (w_wr_tsr && !apb.pwdata[TSR_UDF_BIT]) begin
            udf_d = 1'b0;
        end
        if (w_ovf_set) begin
            ovf_d = 1'b1;
        end
        if (w_udf_set) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tdr_q  <= '0;
            tcnt_q <= '0;
            load_q <= 1'b0;
            dir_q  <= 1'b0;
            en_q   <= 1'b0;
            cks_q  <= CKS_DIV2;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            tdr_q  <= tdr_d;
            tcnt_q <= tcnt_d;
            load_q <= load_d;
            dir_q  <= dir_d;
            en_q   <= en_d;
            cks_q  <= cks_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    assign tmr_ovf = ovf_q;
    assign tmr_udf = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_timer_8bit.sv
// ============================================================================
//  Module      : tb_apb_timer_8bit
//  Description : Directed self-checking bench for apb_timer_8bit. Stimulus is
//                a linear sequence of APB transfers; every expected value is
//                hand-computed from the register map and prescaler timing.
//                Edge numbering below: E0 is the pclk edge that commits the
//                enabling TCR write; a read sampled in its access phase
//                shows state after the previous edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_timer_8bit;
    import apb_timer_pkg::*;

    logic pclk;
    logic preset;
    logic tmr_ovf;
    logic tmr_udf;

    int checks = 0;
    int errors = 0;

    apb_timer_8bit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    apb_timer_8bit #(.ADDR_W(8), .DATA_W(8)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .apb     (bus),
        .tmr_ovf (tmr_ovf),
        .tmr_udf (tmr_udf)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [7:0] d, output logic err);
        @(negedge pclk);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = a;
        bus.pwdata  = d;
        @(negedge pclk);
        bus.penable = 1'b1;
        #2 err = bus.pslverr;
        @(posedge pclk);
        #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [7:0] d, output logic err,
                          output logic rdy);
        @(negedge pclk);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = a;
        @(negedge pclk);
        bus.penable = 1'b1;
        #2;
        d   = bus.prdata;
        err = bus.pslverr;
        rdy = bus.pready;
        @(posedge pclk);
        #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic       err;
        logic       rdy;

        preset      = 1'b1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 8'h00;
        bus.pwdata  = 8'h00;
        repeat (3) @(negedge pclk);
        preset = 1'b0;

        // ---------------- Reset state ----------------
        chk("rst_ovf", {7'd0, tmr_ovf}, 8'h00);
        chk("rst_udf", {7'd0, tmr_udf}, 8'h00);
        for (int a = 0; a < 4; a++) begin
            apb_rd(8'(a), rd, err, rdy);
            chk($sformatf("rst_rd%0d", a), rd, 8'h00);
            chk($sformatf("rst_err%0d", a), {7'd0, err}, 8'h00);
            chk($sformatf("rst_rdy%0d", a), {7'd0, rdy}, 8'h01);
        end

        // ---------------- Load priority ----------------
        apb_wr(ADDR_TDR, 8'h55, err);
        apb_wr(ADDR_TCR, 8'h90, err);
        repeat (100) @(negedge pclk);
        apb_rd(ADDR_TCNT, rd, err, rdy);
        chk("load_tcnt", rd, 8'h55);
        apb_rd(ADDR_TSR, rd, err, rdy);
        chk("load_tsr", rd, 8'h00);

        // ---------------- Reserved bits / error responses ----------------
        apb_wr(ADDR_TCR, 8'hFF, err);
        apb_rd(ADDR_TCR, rd, err, rdy);
        chk("tcr_rsvd", rd, 8'hB3);
        apb_wr(ADDR_TCR, 8'h00, err);
        apb_wr(ADDR_TCNT, 8'hAA, err);
        chk("wr_tcnt_err", {7'd0, err}, 8'h01);
        apb_rd(ADDR_TCNT, rd, err, rdy);
        chk("tcnt_kept", rd, 8'h55);
        chk("rd_tcnt_err", {7'd0, err}, 8'h00);
        apb_wr(8'h04, 8'h12, err);
        chk("wr_04_err", {7'd0, err}, 8'h01);
        apb_rd(8'h04, rd, err, rdy);
        chk("rd_04_err", {7'd0, err}, 8'h01);
        chk("rd_04_data", rd, 8'h00);
        apb_rd(ADDR_TDR, rd, err, rdy);
        chk("tdr_kept", rd, 8'h55);

        // ---------------- Down /4 from 0xFF: underflow at E1024 ----------------
        apb_wr(ADDR_TDR, 8'hFF, err);
        apb_wr(ADDR_TCR, 8'h81, err);
        apb_wr(ADDR_TCR, 8'h31, err);          // commit E0
        repeat (1022) @(negedge pclk);
        chk("d4_udf_early", {7'd0, tmr_udf}, 8'h00);
        apb_rd(ADDR_TSR, rd, err, rdy);        // after E1023
        chk("d4_tsr_early", rd, 8'h00);
        apb_rd(ADDR_TSR, rd, err, rdy);        // after E1025
        chk("d4_tsr_udf", rd, 8'h02);
        chk("d4_udf_pin", {7'd0, tmr_udf}, 8'h01);
        apb_rd(ADDR_TCNT, rd, err, rdy);       // after E1027
        chk("d4_tcnt", rd, 8'hFF);
        apb_wr(ADDR_TSR, 8'h00, err);
        apb_rd(ADDR_TSR, rd, err, rdy);
        chk("d4_tsr_clr", rd, 8'h00);
        apb_wr(ADDR_TCR, 8'h00, err);

        // ---------------- Up /16 from 0x00: overflow at E4096 ----------------
        apb_wr(ADDR_TDR, 8'h00, err);
        apb_wr(ADDR_TCR, 8'h80, err);
        apb_wr(ADDR_TCR, 8'h03, err);
        apb_wr(ADDR_TCR, 8'h13, err);          // commit E0
        repeat (4094) @(negedge pclk);
        chk("u16_ovf_early", {7'd0, tmr_ovf}, 8'h00);
        apb_rd(ADDR_TSR, rd, err, rdy);        // after E4095
        chk("u16_tsr_early", rd, 8'h00);
        apb_rd(ADDR_TSR, rd, err, rdy);        // after E4097
        chk("u16_tsr_ovf", rd, 8'h01);
        chk("u16_ovf_pin", {7'd0, tmr_ovf}, 8'h01);
        apb_rd(ADDR_TCNT, rd, err, rdy);       // after E4099
        chk("u16_tcnt", rd, 8'h00);
        apb_wr(ADDR_TCR, 8'h00, err);
        apb_wr(ADDR_TSR, 8'h00, err);
        apb_rd(ADDR_TSR, rd, err, rdy);
        chk("u16_tsr_clr", rd, 8'h00);

        // ---------------- Down /2 from 0x02 ----------------
        apb_wr(ADDR_TDR, 8'h02, err);
        apb_wr(ADDR_TCR, 8'hA0, err);
        apb_wr(ADDR_TCR, 8'h30, err);          // commit E0
        bus.psel    = 1'b1;
        bus.pwrite  = 1'b0;
        bus.paddr   = ADDR_TCNT;
        bus.penable = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            @(negedge pclk);                   // state after Ek
            if (k == 2) chk("d2_tcnt_e2", bus.prdata, 8'h01);
            if (k == 4) begin
                chk("d2_tcnt_e4", bus.prdata, 8'h00);
                chk("d2_udf_e4", {7'd0, tmr_udf}, 8'h00);
            end
            if (k == 6) begin
                chk("d2_tcnt_e6", bus.prdata, 8'hFF);
                chk("d2_udf_e6", {7'd0, tmr_udf}, 8'h01);
            end
            bus.penable = ~bus.penable;
        end
        bus.psel    = 1'b0;
        bus.penable = 1'b0;

        apb_wr(ADDR_TSR, 8'hFF, err);          // commit E9: writing 1 keeps flag
        apb_rd(ADDR_TSR, rd, err, rdy);        // after E10
        chk("d2_tsr_w1", rd, 8'h02);
        repeat (505) @(negedge pclk);
        apb_wr(ADDR_TSR, 8'h01, err);          // commit E518, same edge as underflow
        apb_rd(ADDR_TSR, rd, err, rdy);
        chk("d2_set_wins", rd, 8'h02);
        apb_wr(ADDR_TSR, 8'h01, err);          // no underflow now: clears UDF
        apb_rd(ADDR_TSR, rd, err, rdy);
        chk("d2_tsr_clr", rd, 8'h00);
        chk("d2_udf_pin_clr", {7'd0, tmr_udf}, 8'h00);
        apb_wr(ADDR_TCR, 8'h00, err);

        // ---------------- Reset mid-operation ----------------
        apb_wr(ADDR_TDR, 8'h10, err);
        apb_wr(ADDR_TCR, 8'h80, err);
        apb_wr(ADDR_TCR, 8'h11, err);
        repeat (50) @(negedge pclk);
        #3 preset = 1'b1;
        #4;
        chk("mid_rst_ovf", {7'd0, tmr_ovf}, 8'h00);
        chk("mid_rst_udf", {7'd0, tmr_udf}, 8'h00);
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        apb_rd(ADDR_TDR, rd, err, rdy);
        chk("mid_rst_tdr", rd, 8'h00);
        apb_rd(ADDR_TCR, rd, err, rdy);
        chk("mid_rst_tcr", rd, 8'h00);
        apb_rd(ADDR_TCNT, rd, err, rdy);
        chk("mid_rst_tcnt", rd, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
